// File: rtl/pattern_pkg.sv
// Shared types and constants for the serial pattern burst generator.
package pattern_pkg;

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_PAT  = 4'b0010,
        S_GAP  = 4'b0100,
        S_DONE = 4'b1000
    } state_t;

    localparam logic BIT_B = 1'b1;
    localparam logic BIT_C = 1'b0;

    // B B C B, transmitted MSB first
    localparam logic [3:0] DEFAULT_PATTERN = {BIT_B, BIT_B, BIT_C, BIT_B};

endpackage

// File: rtl/pattern_tx_ctr.sv
// Loadable down-counter with terminal flag; serves both the bit index and the gap countdown.
module pattern_tx_ctr
    import pattern_pkg::*;
#(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         tc
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/pattern_tx_gen.sv
// Serial pattern burst generator: count repeats of PATTERN separated by gap filler bits.
// Build option: define PATTERN_TX_STALL_EN to honour ready_i; otherwise one bit moves every cycle.
//
// state  | meaning
// S_IDLE | waiting for start_i
// S_PAT  | shifting out PATTERN bits, MSB first
// S_GAP  | shifting out C filler bits between patterns
// S_DONE | one-cycle done_o pulse, then back to idle
module pattern_tx_gen
    import pattern_pkg::*;
#(
    parameter logic [3:0] PATTERN = DEFAULT_PATTERN,
    parameter int         CNT_W   = 8,
    parameter int         GAP_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic [GAP_W-1:0] gap_i,
    input  logic             ready_i,
    output logic             data_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] sent_o
);

    state_t state_q;
    state_t state_d;

    logic [CNT_W-1:0] count_q;
    logic [GAP_W-1:0] gap_q;
    logic [1:0]       bit_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             bit_tc;
    logic             gap_tc;
    logic             ready_eff;
    logic             xfer;
    logic             start_ok;
    logic             last_bit;
    logic             last_pat;
    logic             bit_load;
    logic             bit_dec;
    logic             gap_load;
    logic             gap_dec;

`ifdef PATTERN_TX_STALL_EN
    assign ready_eff = ready_i;
`else
    // port kept for interface compatibility; flow control is disabled in this build
    assign ready_eff = ready_i | 1'b1;
`endif

    assign start_ok = (state_q == S_IDLE) && start_i;
    assign xfer     = valid_o && ready_eff;
    assign last_bit = (state_q == S_PAT) && xfer && bit_tc;
    assign last_pat = ((sent_o + CNT_W'(1)) == count_q);

    // bit counter holds the remaining-bit index, so PATTERN[bit_cnt] is PATTERN[3-idx]
    assign bit_load = (state_q != S_PAT) || last_bit;
    assign bit_dec  = (state_q == S_PAT) && xfer;
    assign gap_load = (state_q != S_GAP);
    assign gap_dec  = (state_q == S_GAP) && xfer;

    pattern_tx_ctr #(.W(2)) u_bit_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (bit_load),
        .load_val (2'd3),
        .dec      (bit_dec),
        .cnt      (bit_cnt),
        .tc       (bit_tc)
    );

    pattern_tx_ctr #(.W(GAP_W)) u_gap_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (gap_load),
        .load_val (gap_q - GAP_W'(1)),
        .dec      (gap_dec),
        .cnt      (gap_cnt),
        .tc       (gap_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            gap_q   <= '0;
            sent_o  <= '0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                count_q <= count_i;
                gap_q   <= gap_i;
                sent_o  <= '0;
            end else if (last_bit) begin
                sent_o  <= sent_o + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = (count_i != '0) ? S_PAT : S_DONE;
                end
            end
            S_PAT: begin
                if (last_bit) begin
                    if (last_pat) begin
                        state_d = S_DONE;
                    end else if (gap_q != '0) begin
                        state_d = S_GAP;
                    end else begin
                        state_d = S_PAT;
                    end
                end
            end
            S_GAP: begin
                if (xfer && gap_tc) begin
                    state_d = S_PAT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        data_o  = BIT_C;
        valid_o = 1'b0;
        busy_o  = 1'b1;
        done_o  = 1'b0;
        unique case (state_q)
            S_IDLE: busy_o = 1'b0;
            S_PAT: begin
                valid_o = 1'b1;
                data_o  = PATTERN[bit_cnt];
            end
            S_GAP: begin
                valid_o = 1'b1;
                data_o  = BIT_C;
            end
            S_DONE:  done_o = 1'b1;
            default: busy_o = 1'b0;
        endcase
    end

endmodule

// File: doc/pattern_tx_gen.md
PATTERN_TX_GEN -- requirements
Module: pattern_tx_gen

Interface
REQ-001 Parameter PATTERN, default 4'b1101, is the serial pattern (B=1, C=0, i.e. B B C B) and is sent MSB first.
REQ-002 Parameter CNT_W, default 8, is the width of the repeat count and sent count.
REQ-003 Parameter GAP_W, default 4, is the width of the gap length.
REQ-004 Port clk: input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 Port rst: input, 1 bit, asynchronous active-low reset.
REQ-006 Port start_i: input, 1 bit, starts a burst; sampled only in S_IDLE.
REQ-007 Port count_i: input, CNT_W bits, number of pattern repeats in the burst.
REQ-008 Port gap_i: input, GAP_W bits, number of C (0) filler bits between consecutive patterns.
REQ-009 Port ready_i: input, 1 bit, downstream accept.
REQ-010 Port data_o: output, 1 bit, serial data bit.
REQ-011 Port valid_o: output, 1 bit, data_o is meaningful.
REQ-012 Port busy_o: output, 1 bit, high while a burst is in progress.
REQ-013 Port done_o: output, 1 bit, single-cycle pulse at the end of a burst.
REQ-014 Port sent_o: output, CNT_W bits, number of complete patterns transferred in the current or last burst.

Function
REQ-015 The FSM shall be one-hot with four states: S_IDLE=4'b0001, S_PAT=4'b0010, S_GAP=4'b0100, S_DONE=4'b1000.
REQ-016 S_IDLE with start_i=1 and count_i!=0 shall latch count_i and gap_i, clear sent_o and the bit index, and go to S_PAT.
REQ-017 S_IDLE with start_i=1 and count_i==0 shall go to S_DONE without asserting valid_o.
REQ-018 start_i in any state other than S_IDLE shall be ignored, and the latched count and gap shall remain unchanged.
REQ-019 In S_PAT, valid_o shall be 1 and data_o shall be PATTERN[3-idx].
REQ-020 A bit transfers on a cycle with valid_o=1 and ready_i=1; idx shall advance only on a transfer.
REQ-021 While valid_o=1 and ready_i=0, data_o, valid_o and idx shall hold stable.
REQ-022 On transfer of the last pattern bit, sent_o shall increment.
REQ-023 After the last pattern bit, if sent_o+1 equals the latched count, the FSM shall go to S_DONE.
REQ-024 Otherwise, after the last pattern bit, the FSM shall go to S_GAP if the latched gap is nonzero, or else to S_PAT with idx=0 (back-to-back patterns).
REQ-025 In S_GAP, valid_o shall be 1 and data_o shall be 0; the FSM shall return to S_PAT after exactly gap transfers.
REQ-026 S_DONE shall drive done_o=1 and valid_o=0 for one cycle, then go to S_IDLE.
REQ-027 busy_o shall be 1 in S_PAT, S_GAP and S_DONE.
REQ-028 The first bit shall appear on data_o/valid_o the cycle after start_i is accepted (latency 1).
REQ-029 The stream shall contain exactly count occurrences of PATTERN under an overlapping detector, for any gap value including 0.
REQ-030 sent_o shall hold its final value after done_o until the next accepted start_i.
REQ-031 When the FSM is not in S_PAT or S_GAP, valid_o shall be 0 and data_o shall be 0.

Reset
REQ-032 rst=0 shall asynchronously force the FSM to S_IDLE and all outputs, counters and latched values to 0, including in the middle of a burst.
REQ-033 A burst interrupted by reset shall not resume and shall not pulse done_o.
REQ-034 Reset deassertion shall be synchronous to clk.

Configuration
REQ-035 Macro PATTERN_TX_STALL_EN defined: ready_i shall be honoured as in REQ-020 and REQ-021.
REQ-036 Macro PATTERN_TX_STALL_EN undefined: ready_i shall be ignored and treated as constant 1, so one bit transfers per cycle; the port shall remain present.

Structure
REQ-037 Package pattern_pkg shall hold the state encodings, the B/C bit constants and the default PATTERN; pattern_tx_gen shall import it.
REQ-038 Sub-module pattern_tx_ctr shall provide the shared loadable down-counter with terminal flag, reused for the bit index and the gap countdown.

Verification
REQ-039 Stall macro off, count_i=3, gap_i=0 -> data_o=110111011101 on 12 consecutive valid cycles; done_o pulses 1 cycle later; sent_o=3; overlapping 1101 detector counts 3.
REQ-040 count_i=2, gap_i=2 -> stream 1101 00 1101; valid_o is high for 10 cycles; detector counts 2; sent_o=2.
REQ-041 Stall macro on, count_i=1, ready_i=0 on the 2nd and 3rd valid cycles -> data_o holds 1 through the stall; the full sequence is 1,1,0,1; done_o fires once.
REQ-042 count_i=0 -> valid_o is never 1; done_o pulses the cycle after start; sent_o=0.
REQ-043 count_i=5, rst=0 asserted mid-gap -> all outputs go to 0 immediately; no done_o pulse; a new start_i with count_i=1 works normally.
REQ-044 start_i reasserted with count_i=9 during a burst with count_i=2 -> the burst still ends with sent_o=2.
